// File: rtl/vc32_pkg.sv
// Shared encodings for the vc32 memory path: arbiter states, grant and read-request codes.
package vc32_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StGap
    } arb_state_e;

    typedef enum logic {
        OwnerM0 = 1'b0,
        OwnerM1 = 1'b1
    } owner_e;

    // One-hot grant codes
    localparam logic [1:0] GntNone = 2'b00;
    localparam logic [1:0] GntM0   = 2'b01;
    localparam logic [1:0] GntM1   = 2'b10;

    // Read-request codes
    localparam logic [1:0] RreqNone = 2'b00;
    localparam logic [1:0] RreqLo   = 2'b01;
    localparam logic [1:0] RreqHi   = 2'b10;
    localparam logic [1:0] RreqWord = 2'b11;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the two master request channels, the sequencer channel and the grant.
// slave: the arbiter's view; master: the view of the masters plus sequencer around it.
interface mem_arb_if #(
    parameter int unsigned RV = 16,
    parameter int unsigned PA = 22
);

    logic [PA-1:RV/16] m0_addrp;
    logic [1:0]        m0_rreq;
    logic [RV/8-1:0]   m0_wmask;
    logic [RV-1:0]     m0_wdata;
    logic              m0_rdone;
    logic              m0_wdone;

    logic [PA-1:RV/16] m1_addrp;
    logic [1:0]        m1_rreq;
    logic [RV/8-1:0]   m1_wmask;
    logic [RV-1:0]     m1_wdata;
    logic              m1_rdone;
    logic              m1_wdone;

    logic [RV-1:0]     m_rdata;

    logic [PA-1:RV/16] s_addrp;
    logic [1:0]        s_rreq;
    logic [RV/8-1:0]   s_wmask;
    logic [RV-1:0]     s_wdata;
    logic [RV-1:0]     s_rdata;
    logic              s_rdone;
    logic              s_wdone;

    logic [1:0]        grant;

    modport slave (
        input  m0_addrp, m0_rreq, m0_wmask, m0_wdata,
        input  m1_addrp, m1_rreq, m1_wmask, m1_wdata,
        input  s_rdata, s_rdone, s_wdone,
        output m0_rdone, m0_wdone, m1_rdone, m1_wdone, m_rdata,
        output s_addrp, s_rreq, s_wmask, s_wdata, grant
    );

    modport master (
        output m0_addrp, m0_rreq, m0_wmask, m0_wdata,
        output m1_addrp, m1_rreq, m1_wmask, m1_wdata,
        output s_rdata, s_rdone, s_wdone,
        input  m0_rdone, m0_wdone, m1_rdone, m1_wdone, m_rdata,
        input  s_addrp, s_rreq, s_wmask, s_wdata, grant
    );

endinterface

// File: rtl/mem_arb.sv
// Two-master arbiter in front of the byte-bus sequencer. Alternates on contention,
// holds ownership until the sequencer reports completion, and inserts one idle GAP
// cycle after every transaction so the sequencer sees a zero request while recovering.
module mem_arb
    import vc32_pkg::*;
#(
    parameter int unsigned RV = 16,
    parameter int unsigned PA = 22
) (
    input logic      clk,
    input logic      reset_in,
    mem_arb_if.slave bus
);

    localparam int unsigned AW = PA - RV / 16;

    arb_state_e state_q;
    owner_e     last_owner_q;
    logic [1:0] grant_q;

    logic pend0;
    logic pend1;
    logic done_any;
    logic gnt0;
    logic gnt1;

    assign pend0    = (|bus.m0_rreq) || (|bus.m0_wmask);
    assign pend1    = (|bus.m1_rreq) || (|bus.m1_wmask);
    // Simultaneous rdone and wdone count as one completion
    assign done_any = bus.s_rdone || bus.s_wdone;

    // Arbitration FSM with registered grant and fairness history
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q      <= StIdle;
            grant_q      <= GntNone;
            last_owner_q <= OwnerM1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pend0 && (!pend1 || last_owner_q == OwnerM1)) begin
                        state_q <= StOwn0;
                        grant_q <= GntM0;
                    end else if (pend1) begin
                        state_q <= StOwn1;
                        grant_q <= GntM1;
                    end
                end
                StOwn0: begin
                    if (done_any) begin
                        state_q      <= StGap;
                        grant_q      <= GntNone;
                        last_owner_q <= OwnerM0;
                    end
                end
                StOwn1: begin
                    if (done_any) begin
                        state_q      <= StGap;
                        grant_q      <= GntNone;
                        last_owner_q <= OwnerM1;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                    grant_q <= GntNone;
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= GntNone;
                end
            endcase
        end
    end

    // Forward the owner's request to the sequencer; drive zeros when nobody owns the bus
    always_comb begin
        bus.s_addrp = {AW{1'b0}};
        bus.s_rreq  = RreqNone;
        bus.s_wmask = '0;
        bus.s_wdata = {RV{1'b0}};
        case (state_q)
            StOwn0: begin
                bus.s_addrp = bus.m0_addrp;
                bus.s_rreq  = bus.m0_rreq;
                bus.s_wmask = bus.m0_wmask;
                bus.s_wdata = bus.m0_wdata;
            end
            StOwn1: begin
                bus.s_addrp = bus.m1_addrp;
                bus.s_rreq  = bus.m1_rreq;
                bus.s_wmask = bus.m1_wmask;
                bus.s_wdata = bus.m1_wdata;
            end
            default: ;
        endcase
        // Reset blocks requests combinationally, before the state register clears
        if (reset_in) begin
            bus.s_rreq  = RreqNone;
            bus.s_wmask = '0;
        end
    end

    // Completions route only to the current owner; done pulses outside ownership vanish
    assign gnt0 = grant_q[0] && !reset_in;
    assign gnt1 = grant_q[1] && !reset_in;

    assign bus.m0_rdone = bus.s_rdone && gnt0;
    assign bus.m0_wdone = bus.s_wdone && gnt0;
    assign bus.m1_rdone = bus.s_rdone && gnt1;
    assign bus.m1_wdone = bus.s_wdone && gnt1;
    assign bus.m_rdata  = bus.s_rdata;
    assign bus.grant    = grant_q;

endmodule
